// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam logic [31:0] IMEM_BASE_DEF = 32'h0600_2000;
  localparam logic [31:0] NOP_INSTR     = 32'h7800_0000;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;

  // Word-aligned address that falls inside [base, base + 4*depth).
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned depth);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && ((off >> 2) < depth) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Program storage: DEPTH x 32, combinational read port, synchronous write port.
module imem_array #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction-memory responder with host load port.
// Optional IMEM_OOR_ERR_EN adds the err output for out-of-range reads/loads.
module imem_responder
  import imem_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE = IMEM_BASE_DEF,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        en,
  input  logic        wr,
  output logic        data_valid,
  output logic [31:0] data_out,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
`ifdef IMEM_OOR_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  imem_state_t   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [AW-1:0] req_idx_q, req_idx_d;
  logic          req_ok_q, req_ok_d;
  logic          data_valid_q;
  logic [31:0]   data_out_q;
  logic          accept;

  logic          addr_ok, ld_ok;
  logic [AW-1:0] addr_idx, ld_idx;
  logic [31:0]   rd_data;
  logic          unused_wr;

  assign unused_wr = wr;
  assign addr_ok   = in_range(addr, IMEM_BASE, DEPTH);
  assign ld_ok     = in_range(ld_addr, IMEM_BASE, DEPTH);
  assign addr_idx  = AW'((addr - IMEM_BASE) >> 2);
  assign ld_idx    = AW'((ld_addr - IMEM_BASE) >> 2);

  imem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk_i   (clk),
    .we_i    (ld_en & ld_ok),
    .waddr_i (ld_idx),
    .wdata_i (ld_data),
    .raddr_i (req_idx_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    req_addr_d = req_addr_q;
    req_idx_d  = req_idx_q;
    req_ok_d   = req_ok_q;
    accept     = 1'b0;
    case (state_q)
      IDLE: accept = en;
      WAIT: begin
        // A flush or redirect while waiting drops the pending request.
        if (!en)                     state_d = IDLE;
        else if (addr != req_addr_q) accept  = 1'b1;
        else if (count_q == CW'(1)) begin
          state_d = RESP;
          count_d = '0;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      req_addr_d = addr;
      req_idx_d  = addr_idx;
      req_ok_d   = addr_ok;
      count_d    = CNT_INIT;
      state_d    = (LATENCY == 1) ? RESP : WAIT;
    end
  end

  // The word is sampled at the edge leaving RESP, before any same-edge load lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      req_addr_q   <= '0;
      req_idx_q    <= '0;
      req_ok_q     <= 1'b0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      req_addr_q   <= req_addr_d;
      req_idx_q    <= req_idx_d;
      req_ok_q     <= req_ok_d;
      data_valid_q <= (state_q == RESP);
      if (state_q == RESP) data_out_q <= req_ok_q ? rd_data : NOP_INSTR;
    end
  end

  assign data_valid = data_valid_q;
  assign data_out   = data_out_q;

`ifdef IMEM_OOR_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= ((state_q == RESP) && !req_ok_q) || (ld_en && !ld_ok);
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus randomized traffic.
module tb_imem_responder;

  localparam logic [31:0] BASE  = 32'h0600_2000;
  localparam int unsigned DEPTH = 4096;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] NOP   = 32'h7800_0000;

  logic        clk = 1'b0;
  logic        rst, en, wr, ld_en;
  logic [31:0] addr, ld_addr, ld_data;
  logic        data_valid;
  logic [31:0] data_out;
`ifdef IMEM_OOR_ERR_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_responder #(.IMEM_BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .en         (en),
    .wr         (wr),
    .data_valid (data_valid),
    .data_out   (data_out),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data)
`ifdef IMEM_OOR_ERR_EN
    ,
    .err        (err)
`endif
  );

  // Reference model: words by index, and a pending request timed in clock edges.
  logic [31:0] mmem [int];
  bit          pend = 1'b0;
  logic [31:0] p_addr = '0;
  longint      acc = 0;
  longint      cyc = 0;
  bit          exp_valid = 1'b0;
  bit          exp_err = 1'b0;
  logic [31:0] exp_dout = '0;

  function automatic bit ref_oor(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off < 0) || (off % 4 != 0) || (off / 4 >= longint'(DEPTH));
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    longint off;
    int     idx;
    if (ref_oor(a)) return NOP;
    off = longint'(a) - longint'(BASE);
    idx = int'(off / 4);
    if (mmem.exists(idx)) return mmem[idx];
    return 32'hBAD0_BAD0;
  endfunction

  initial forever begin
    bit v;
    bit e;
    @(posedge clk);
    v = 1'b0;
    e = 1'b0;
    cyc = cyc + 1;
    if (rst) begin
      pend     = 1'b0;
      exp_dout = '0;
    end else if (pend) begin
      if (cyc - acc < longint'(LAT)) begin
        if (!en) pend = 1'b0;
        else if (addr != p_addr) begin
          acc    = cyc;
          p_addr = addr;
        end
      end else begin
        v        = 1'b1;
        exp_dout = ref_word(p_addr);
        e        = ref_oor(p_addr);
        pend     = 1'b0;
      end
    end else if (en) begin
      pend   = 1'b1;
      acc    = cyc;
      p_addr = addr;
    end
    if (ld_en) begin
      if (!ref_oor(ld_addr)) mmem[int'((longint'(ld_addr) - longint'(BASE)) / 4)] = ld_data;
      else if (!rst) e = 1'b1;
    end
    exp_valid = v;
    exp_err   = e;
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; wr = 1'b0; ld_en = 1'b0;
    addr = BASE; ld_addr = BASE; ld_data = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (data_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %0b exp 0", data_valid);
    end
    n_checks++;
    if (data_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_dout got %08h exp 00000000", data_out);
    end
`ifdef IMEM_OOR_ERR_EN
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL reset_err got %0b exp 0", err);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 17; i++) begin
      ld_en   = 1'b1;
      ld_addr = BASE + 32'(4 * ((i == 16) ? (DEPTH - 1) : i));
      ld_data = $urandom;
      @(negedge clk);
    end
    ld_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    ld_en = 1'b1; ld_addr = BASE; ld_data = 32'hDEAD_0001;
    @(negedge clk);
    ld_addr = BASE + 32'd4; ld_data = 32'hDEAD_0002;
    @(negedge clk);
    ld_en = 1'b0; en = 1'b1; addr = BASE;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (data_valid !== 1'(c == 3)) begin
        n_fail++; $display("FAIL rd1_valid c=%0d got %0b exp %0b", c, data_valid, c == 3);
      end
      if (c == 3) begin
        en = 1'b0;
        n_checks++;
        if (data_out !== 32'hDEAD_0001) begin
          n_fail++; $display("FAIL rd1_data got %08h exp DEAD0001", data_out);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int got;
    int t0;
    logic [31:0] expw [2];
    expw[0] = 32'hDEAD_0001;
    expw[1] = 32'hDEAD_0002;
    got = 0; t0 = 0;
    en = 1'b1; addr = BASE;
    for (int c = 0; c < 15 && got < 2; c++) begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        n_checks++;
        if (data_out !== expw[got]) begin
          n_fail++; $display("FAIL b2b_data[%0d] got %08h exp %08h", got, data_out, expw[got]);
        end
        if (got == 1) begin
          n_checks++;
          if (c - t0 != int'(LAT) + 1) begin
            n_fail++; $display("FAIL b2b_spacing got %0d exp %0d", c - t0, LAT + 1);
          end
        end
        t0 = c;
        got++;
        addr = BASE + 32'(4 * got);
        if (got == 2) en = 1'b0;
      end
    end
    n_checks++;
    if (got != 2) begin
      n_fail++; $display("FAIL b2b_count got %0d exp 2", got);
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_flush();
    en = 1'b1; addr = BASE;
    @(negedge clk);
    addr = BASE + 32'd4;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (data_valid !== 1'(c == 3)) begin
        n_fail++; $display("FAIL flush_valid c=%0d got %0b exp %0b", c, data_valid, c == 3);
      end
      if (c == 3) begin
        en = 1'b0;
        n_checks++;
        if (data_out !== 32'hDEAD_0002) begin
          n_fail++; $display("FAIL flush_data got %08h exp DEAD0002", data_out);
        end
      end
    end
  endtask

  task automatic test_oor();
    logic [31:0] oor [3];
    bit found;
    oor[0] = 32'h0600_1FFC;
    oor[1] = 32'h0600_2002;
    oor[2] = BASE + 32'(4 * DEPTH);
    for (int k = 0; k < 3; k++) begin
      en = 1'b1; addr = oor[k]; found = 1'b0;
      for (int c = 0; c < 6 && !found; c++) begin
        @(negedge clk);
        if (data_valid === 1'b1) begin
          found = 1'b1;
          en = 1'b0;
          n_checks++;
          if (data_out !== NOP) begin
            n_fail++; $display("FAIL oor_data[%0d] got %08h exp %08h", k, data_out, NOP);
          end
`ifdef IMEM_OOR_ERR_EN
          n_checks++;
          if (err !== 1'b1) begin
            n_fail++; $display("FAIL oor_err[%0d] got %0b exp 1", k, err);
          end
`endif
        end
      end
      n_checks++;
      if (!found) begin
        n_fail++; $display("FAIL oor_timeout[%0d] got no valid exp valid", k);
      end
      en = 1'b0;
      @(negedge clk);
    end
`ifdef IMEM_OOR_ERR_EN
    ld_en = 1'b1; ld_addr = BASE - 32'd4; ld_data = 32'h1111_2222;
    @(negedge clk);
    ld_en = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL oor_ld_err got %0b exp 1", err);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL oor_ld_err_clear got %0b exp 0", err);
    end
`endif
  endtask

  task automatic test_read_before_write();
    bit found;
    en = 1'b1; addr = BASE;
    repeat (2) @(negedge clk);
    ld_en = 1'b1; ld_addr = BASE; ld_data = 32'h1234_5678;
    @(negedge clk);
    ld_en = 1'b0; en = 1'b0;
    n_checks++;
    if (data_valid !== 1'b1 || data_out !== 32'hDEAD_0001) begin
      n_fail++; $display("FAIL rbw_old got v=%0b %08h exp v=1 DEAD0001", data_valid, data_out);
    end
    @(negedge clk);
    en = 1'b1; found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        found = 1'b1; en = 1'b0;
        n_checks++;
        if (data_out !== 32'h1234_5678) begin
          n_fail++; $display("FAIL rbw_new got %08h exp 12345678", data_out);
        end
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL rbw_timeout got no valid exp valid");
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    bit found;
    en = 1'b1; addr = BASE + 32'd4;
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (data_valid !== 1'b0 || data_out !== 32'h0) begin
      n_fail++; $display("FAIL rstw_out got v=%0b %08h exp v=0 00000000", data_valid, data_out);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (data_valid !== 1'b0) begin
        n_fail++; $display("FAIL rstw_novalid c=%0d got %0b exp 0", c, data_valid);
      end
    end
    en = 1'b1; found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        found = 1'b1; en = 1'b0;
        n_checks++;
        if (data_out !== 32'hDEAD_0002) begin
          n_fail++; $display("FAIL rstw_after got %08h exp DEAD0002", data_out);
        end
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL rstw_timeout got no valid exp valid");
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] pool [11];
    for (int i = 0; i < 8; i++) pool[i] = BASE + 32'(4 * i);
    pool[8]  = BASE + 32'(4 * (DEPTH - 1));
    pool[9]  = BASE - 32'd4;
    pool[10] = BASE + 32'd2;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      n_checks++;
      if (data_valid !== exp_valid || data_out !== exp_dout) begin
        n_fail++;
        $display("FAIL rand c=%0d got v=%0b %08h exp v=%0b %08h", c, data_valid, data_out, exp_valid, exp_dout);
      end
`ifdef IMEM_OOR_ERR_EN
      n_checks++;
      if (err !== exp_err) begin
        n_fail++; $display("FAIL rand_err c=%0d got %0b exp %0b", c, err, exp_err);
      end
`endif
      rst   = ($urandom_range(0, 49) == 0);
      en    = ($urandom_range(0, 9) < 8);
      wr    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) addr = pool[$urandom_range(0, 10)];
      ld_en   = ($urandom_range(0, 4) == 0);
      ld_addr = pool[$urandom_range(0, 10)];
      ld_data = $urandom;
    end
    rst = 1'b0; en = 1'b0; wr = 1'b0; ld_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    preload();
    test_single_read();
    test_back_to_back();
    test_flush();
    test_oor();
    test_read_before_write();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
